// File: rtl/gray_cnt_pkg.sv
// -----------------------------------------------------------------------------
// gray_cnt_pkg
// Shared definitions for the Gray-code counter sequencer:
//   - command opcodes (2-bit, fully decoded)
//   - controller state enum
//   - bin2gray / gray2bin conversion helpers
// The conversion helpers take zero-extended values up to GRAY_MAX_W bits, so
// any counter width up to GRAY_MAX_W uses them unchanged. The caller truncates
// the result to its own WIDTH.
// Optional feature macro: GRAY_CNT_CTRL_DOWN_EN. When it is defined, opcode 00
// becomes RUN_DOWN instead of NOP.
// -----------------------------------------------------------------------------
package gray_cnt_pkg;

   localparam int GRAY_MAX_W = 32;

   localparam logic [1:0] OP_NOP  = 2'b00;
   localparam logic [1:0] OP_LOAD = 2'b01;
   localparam logic [1:0] OP_STEP = 2'b10;
   localparam logic [1:0] OP_RUN  = 2'b11;
`ifdef GRAY_CNT_CTRL_DOWN_EN
   localparam logic [1:0] OP_RUN_DOWN = 2'b00;
`endif

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Prefix XOR from the MSB down. Zero-extended upper bits stay zero.
   function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
      logic [GRAY_MAX_W-1:0] b;
      b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
      for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/gray_cnt_ctrl_if.sv
// -----------------------------------------------------------------------------
// gray_cnt_ctrl_if
// Command and status bundle between the issuing logic (master) and the
// gray_cnt_ctrl sequencer (slave).
//   cmd_valid/cmd_ready/cmd_op/cmd_data : command handshake
//   abort                               : halt an active RUN
//   q, busy, done, aborted              : count value and status pulses
//   dir (GRAY_CNT_CTRL_DOWN_EN only)    : STEP direction, 1 = down
// -----------------------------------------------------------------------------
interface gray_cnt_ctrl_if #(parameter int WIDTH = 4);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [WIDTH-1:0] cmd_data;
   logic             abort;
   logic [WIDTH-1:0] q;
   logic             busy;
   logic             done;
   logic             aborted;
`ifdef GRAY_CNT_CTRL_DOWN_EN
   logic             dir;

   modport master (output cmd_valid, cmd_op, cmd_data, abort, dir,
                   input  cmd_ready, q, busy, done, aborted);
   modport slave  (input  cmd_valid, cmd_op, cmd_data, abort, dir,
                   output cmd_ready, q, busy, done, aborted);
`else
   modport master (output cmd_valid, cmd_op, cmd_data, abort,
                   input  cmd_ready, q, busy, done, aborted);
   modport slave  (input  cmd_valid, cmd_op, cmd_data, abort,
                   output cmd_ready, q, busy, done, aborted);
`endif
endinterface

// File: rtl/gray_cnt_core.sv
// -----------------------------------------------------------------------------
// gray_cnt_core
// WIDTH-bit Gray counter register with its next-code logic.
//   clk, rst   : clock and synchronous active-high reset (q -> 0)
//   en         : advance one code in direction dir (0 = up, 1 = down)
//   ld, ld_val : load ld_val (takes priority over en)
//   q          : current Gray code
//   q_adv      : code that en would produce this cycle. The controller uses it
//                to detect reaching the target on the same edge.
// -----------------------------------------------------------------------------
module gray_cnt_core
   import gray_cnt_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             ld,
   input  logic [WIDTH-1:0] ld_val,
   input  logic             dir,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_adv
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] bin_cur, bin_step;

   // Step in binary at WIDTH bits so the +/-1 wraps modulo 2^WIDTH before the
   // value is re-encoded as Gray code.
   assign bin_cur  = WIDTH'(gray2bin(GRAY_MAX_W'(q_q)));
   assign bin_step = dir ? (bin_cur - ONE) : (bin_cur + ONE);
   assign q_adv    = WIDTH'(bin2gray(GRAY_MAX_W'(bin_step)));

   always_comb begin
      q_d = q_q;
      if (ld) begin
         q_d = ld_val;
      end else if (en) begin
         q_d = q_adv;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/gray_cnt_ctrl.sv
// -----------------------------------------------------------------------------
// gray_cnt_ctrl
// Command-driven sequencer for a Gray-code counter. It accepts LOAD, STEP and
// RUN commands and runs the counter until it reaches a target code.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : gray_cnt_ctrl_if slave
//         - command handshake
//         - abort
//         - q, busy, done, aborted
// Optional feature macro: GRAY_CNT_CTRL_DOWN_EN.
//   - Opcode 00 becomes RUN_DOWN.
//   - STEP follows bus.dir.
// When the macro is undefined, the counter counts up only and opcode 00 is NOP.
// The counter register itself lives in gray_cnt_core. This module contains the
// FSM, the target register and the done/aborted pulse registers.
// -----------------------------------------------------------------------------
module gray_cnt_ctrl
   import gray_cnt_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic           clk,
   input  logic           rst,
   gray_cnt_ctrl_if.slave bus
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] target_q, target_d;
   logic             run_dir_q, run_dir_d;
   logic             done_q, done_d;
   logic             aborted_q, aborted_d;

   logic             accept;
   logic             op_is_run, op_run_dir, step_dir;
   logic             core_en, core_ld, core_dir;
   logic             reach;
   logic [WIDTH-1:0] q_cur, q_adv;

`ifdef GRAY_CNT_CTRL_DOWN_EN
   assign step_dir   = bus.dir;
   assign op_is_run  = (bus.cmd_op == OP_RUN) || (bus.cmd_op == OP_RUN_DOWN);
   assign op_run_dir = (bus.cmd_op == OP_RUN_DOWN);
`else
   assign step_dir   = 1'b0;
   assign op_is_run  = (bus.cmd_op == OP_RUN);
   assign op_run_dir = 1'b0;
`endif

   assign bus.cmd_ready = (state_q == ST_IDLE) && !rst;
   assign accept        = bus.cmd_valid && bus.cmd_ready;
   // Compare the code the next advance would produce. Completion therefore
   // lands on the same edge as the final advance.
   assign reach         = (q_adv == target_q);

   gray_cnt_core #(.WIDTH(WIDTH)) u_core (
      .clk    (clk),
      .rst    (rst),
      .en     (core_en),
      .ld     (core_ld),
      .ld_val (bus.cmd_data),
      .dir    (core_dir),
      .q      (q_cur),
      .q_adv  (q_adv)
   );

   // State, target and pulse registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         target_q  <= '0;
         run_dir_q <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         target_q  <= target_d;
         run_dir_q <= run_dir_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d   = state_q;
      target_d  = target_q;
      run_dir_d = run_dir_q;
      case (state_q)
         ST_IDLE: begin
            if (accept && op_is_run) begin
               state_d   = ST_RUN;
               target_d  = bus.cmd_data;
               run_dir_d = op_run_dir;
            end
         end
         ST_RUN: begin
            if (reach || bus.abort) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output and datapath control
   always_comb begin
      core_en   = 1'b0;
      core_ld   = 1'b0;
      core_dir  = step_dir;
      done_d    = 1'b0;
      aborted_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               case (bus.cmd_op)
                  OP_LOAD: begin
                     core_ld = 1'b1;
                     done_d  = 1'b1;
                  end
                  OP_STEP: begin
                     core_en = 1'b1;
                     done_d  = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
         ST_RUN: begin
            core_dir = run_dir_q;
            // Reaching the target takes priority over a simultaneous abort.
            if (reach) begin
               core_en = 1'b1;
               done_d  = 1'b1;
            end else if (bus.abort) begin
               aborted_d = 1'b1;
            end else begin
               core_en = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign bus.q       = q_cur;
   assign bus.busy    = (state_q == ST_RUN);
   assign bus.done    = done_q;
   assign bus.aborted = aborted_q;

endmodule

// File: tb/tb_gray_cnt_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gray_cnt_ctrl
// Directed bench for gray_cnt_ctrl (WIDTH=4, default build).
//   - A vector table drives back-to-back LOAD/STEP/NOP commands.
//   - Hand-written sequences cover RUN, full lap, abort, pending commands and
//     reset during RUN.
// -----------------------------------------------------------------------------
module tb_gray_cnt_ctrl;
   import gray_cnt_pkg::*;

   localparam int W = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   gray_cnt_ctrl_if #(.WIDTH(W)) bus();

   gray_cnt_ctrl #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] data;
      logic [W-1:0] exp_q;
      logic         exp_done;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] op, input logic [W-1:0] data);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_data  = data;
      tick();
      bus.cmd_valid = 1'b0;
   endtask

   // Called right after the RUN accepting edge. Counts edges until done is
   // visible, together with busy cycles and any aborted/ready seen meanwhile.
   task automatic wait_done(output int edges, output int busy_cnt,
                            output int ab_cnt, output int rdy_cnt);
      edges = 0; busy_cnt = 0; ab_cnt = 0; rdy_cnt = 0;
      while (!bus.done && edges < 40) begin
         if (bus.busy)      busy_cnt++;
         if (bus.aborted)   ab_cnt++;
         if (bus.cmd_ready) rdy_cnt++;
         tick();
         edges++;
      end
   endtask

   initial begin
      int edges, busy_cnt, ab_cnt, rdy_cnt, dcnt;

      vecs[0]  = '{OP_STEP, 4'b0000, 4'b0001, 1'b1};
      vecs[1]  = '{OP_STEP, 4'b0000, 4'b0011, 1'b1};
      vecs[2]  = '{OP_STEP, 4'b0000, 4'b0010, 1'b1};
      vecs[3]  = '{OP_STEP, 4'b0000, 4'b0110, 1'b1};
      vecs[4]  = '{OP_STEP, 4'b0000, 4'b0111, 1'b1};
      vecs[5]  = '{OP_NOP,  4'b1111, 4'b0111, 1'b0};
      vecs[6]  = '{OP_LOAD, 4'b1000, 4'b1000, 1'b1};
      vecs[7]  = '{OP_STEP, 4'b0000, 4'b0000, 1'b1};
      vecs[8]  = '{OP_LOAD, 4'b1010, 4'b1010, 1'b1};
      vecs[9]  = '{OP_STEP, 4'b0000, 4'b1011, 1'b1};
      vecs[10] = '{OP_STEP, 4'b0000, 4'b1001, 1'b1};
      vecs[11] = '{OP_NOP,  4'b0101, 4'b1001, 1'b0};

      bus.cmd_valid = 1'b0;
      bus.cmd_op    = OP_NOP;
      bus.cmd_data  = '0;
      bus.abort     = 1'b0;
`ifdef GRAY_CNT_CTRL_DOWN_EN
      bus.dir       = 1'b0;
`endif

      // Reset
      tick(); tick();
      check("rst_ready_low", 32'(bus.cmd_ready), 32'd0);
      rst = 1'b0;
      #1;
      check("rst_q",       32'(bus.q),         32'd0);
      check("rst_busy",    32'(bus.busy),      32'd0);
      check("rst_done",    32'(bus.done),      32'd0);
      check("rst_aborted", 32'(bus.aborted),   32'd0);
      check("rst_ready",   32'(bus.cmd_ready), 32'd1);
      dcnt = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.done) dcnt++;
      end
      check("idle_no_done", 32'(dcnt), 32'd0);

      // Back-to-back vector table
      for (int i = 0; i < 12; i++) begin
         bus.cmd_valid = 1'b1;
         bus.cmd_op    = vecs[i].op;
         bus.cmd_data  = vecs[i].data;
         tick();
         check($sformatf("vec%0d_q", i),    32'(bus.q),    32'(vecs[i].exp_q));
         check($sformatf("vec%0d_done", i), 32'(bus.done), 32'(vecs[i].exp_done));
         check($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'd0);
      end
      bus.cmd_valid = 1'b0;
      tick();
      check("table_done_clear", 32'(bus.done), 32'd0);

      // RUN to 0010 from 0000: three advances
      issue(OP_LOAD, 4'b0000);
      issue(OP_RUN, 4'b0010);
      check("run1_first_q", 32'(bus.q), 32'b0000);
      wait_done(edges, busy_cnt, ab_cnt, rdy_cnt);
      check("run1_edges", 32'(edges),    32'd3);
      check("run1_busy",  32'(busy_cnt), 32'd3);
      check("run1_q",     32'(bus.q),    32'b0010);
      check("run1_nobusy_at_done", 32'(bus.busy), 32'd0);

      // Same target from q=target: full lap of 16 advances
      issue(OP_RUN, 4'b0010);
      wait_done(edges, busy_cnt, ab_cnt, rdy_cnt);
      check("lap_edges", 32'(edges), 32'd16);
      check("lap_busy",  32'(busy_cnt), 32'd16);
      check("lap_q",     32'(bus.q), 32'b0010);
      tick();
      check("lap_done_pulse", 32'(bus.done), 32'd0);

      // Abort in the fourth cycle of a RUN to 1000
      issue(OP_LOAD, 4'b0000);
      issue(OP_RUN, 4'b1000);
      tick(); tick(); tick();
      check("abort_pre_q", 32'(bus.q), 32'b0010);
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      check("abort_q",       32'(bus.q),       32'b0010);
      check("abort_pulse",   32'(bus.aborted), 32'd1);
      check("abort_no_done", 32'(bus.done),    32'd0);
      check("abort_idle",    32'(bus.busy),    32'd0);
      tick();
      check("abort_pulse_end", 32'(bus.aborted), 32'd0);
      check("abort_hold_q",    32'(bus.q),       32'b0010);

      // Abort coincident with reaching target: completion wins
      issue(OP_LOAD, 4'b0000);
      issue(OP_RUN, 4'b0011);
      tick();
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      check("abtgt_q",       32'(bus.q),       32'b0011);
      check("abtgt_done",    32'(bus.done),    32'd1);
      check("abtgt_aborted", 32'(bus.aborted), 32'd0);

      // Abort in IDLE is ignored
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      tick();
      check("idle_abort_q",  32'(bus.q),       32'b0011);
      check("idle_abort_ab", 32'(bus.aborted), 32'd0);

      // Command held during RUN stays pending, then is accepted on the done cycle
      issue(OP_LOAD, 4'b0000);
      issue(OP_RUN, 4'b0010);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = OP_LOAD;
      bus.cmd_data  = 4'b1111;
      wait_done(edges, busy_cnt, ab_cnt, rdy_cnt);
      check("pend_ready_low", 32'(rdy_cnt), 32'd0);
      check("pend_run_q",     32'(bus.q),   32'b0010);
      check("pend_ready_at_done", 32'(bus.cmd_ready), 32'd1);
      tick();
      bus.cmd_valid = 1'b0;
      check("pend_load_q",    32'(bus.q),    32'b1111);
      check("pend_load_done", 32'(bus.done), 32'd1);

      // Reset mid-RUN with a command held
      issue(OP_LOAD, 4'b0000);
      issue(OP_RUN, 4'b1000);
      tick(); tick(); tick();
      rst           = 1'b1;
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = OP_LOAD;
      bus.cmd_data  = 4'b0101;
      #1;
      check("rstrun_ready_low", 32'(bus.cmd_ready), 32'd0);
      tick();
      check("rstrun_q",       32'(bus.q),       32'd0);
      check("rstrun_busy",    32'(bus.busy),    32'd0);
      check("rstrun_done",    32'(bus.done),    32'd0);
      check("rstrun_aborted", 32'(bus.aborted), 32'd0);
      tick();
      check("rstrun_q_held", 32'(bus.q), 32'd0);
      rst = 1'b0;
      #1;
      check("rstrun_ready_back", 32'(bus.cmd_ready), 32'd1);
      tick();
      bus.cmd_valid = 1'b0;
      check("rstrun_load_q",    32'(bus.q),    32'b0101);
      check("rstrun_load_done", 32'(bus.done), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
